// File: rtl/color_bbox_tracker.sv
// Two-object colour-blob tracker: classifies a raster pixel stream against red/blue
// marker colours and publishes one bounding box per object at the end of each frame.

module color_bbox_obj #(
    parameter int MIN_PIX = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        acc_en_i,
    input  logic        seed_i,
    input  logic        hit_i,
    input  logic        commit_i,
    input  logic [10:0] x_i,
    input  logic [10:0] y_i,
    output logic [10:0] left_o,
    output logic [10:0] right_o,
    output logic [10:0] up_o,
    output logic [10:0] down_o,
    output logic        found_o
);
    localparam logic [10:0] COORD_MAX = 11'h7FF;
    localparam logic [19:0] CNT_MAX   = 20'hF_FFFF;

    logic [10:0] min_x_q, min_x_d, max_x_q, max_x_d;
    logic [10:0] min_y_q, min_y_d, max_y_q, max_y_d;
    logic [19:0] cnt_q, cnt_d;
    logic        enough;

    // Seeding starts from the empty box so the seeding pixel itself still counts.
    always_comb begin
        min_x_d = seed_i ? COORD_MAX : min_x_q;
        max_x_d = seed_i ? 11'd0     : max_x_q;
        min_y_d = seed_i ? COORD_MAX : min_y_q;
        max_y_d = seed_i ? 11'd0     : max_y_q;
        cnt_d   = seed_i ? 20'd0     : cnt_q;
        if (hit_i) begin
            if (x_i < min_x_d) min_x_d = x_i;
            if (x_i > max_x_d) max_x_d = x_i;
            if (y_i < min_y_d) min_y_d = y_i;
            if (y_i > max_y_d) max_y_d = y_i;
            if (cnt_d != CNT_MAX) cnt_d = cnt_d + 20'd1;
        end
    end

    assign enough = (cnt_d >= 20'(MIN_PIX));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            min_x_q <= COORD_MAX;
            max_x_q <= 11'd0;
            min_y_q <= COORD_MAX;
            max_y_q <= 11'd0;
            cnt_q   <= 20'd0;
        end else if (acc_en_i) begin
            min_x_q <= min_x_d;
            max_x_q <= max_x_d;
            min_y_q <= min_y_d;
            max_y_q <= max_y_d;
            cnt_q   <= cnt_d;
        end
    end

    // A sparse frame leaves the last good box in place; only the found flag drops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            left_o  <= 11'd0;
            right_o <= 11'd0;
            up_o    <= 11'd0;
            down_o  <= 11'd0;
            found_o <= 1'b0;
        end else if (commit_i) begin
            found_o <= enough;
            if (enough) begin
                left_o  <= min_x_d;
                right_o <= max_x_d;
                up_o    <= min_y_d;
                down_o  <= max_y_d;
            end
        end
    end
endmodule

module color_bbox_tracker #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int HI_TH    = 160,
    parameter int LO_TH    = 96,
    parameter int MIN_PIX  = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [10:0] i_x,
    input  logic [10:0] i_y,
    input  logic [7:0]  i_r,
    input  logic [7:0]  i_g,
    input  logic [7:0]  i_b,
    input  logic        i_frame_start,
    input  logic        i_frame_end,
    output logic [21:0] o_left,
    output logic [21:0] o_right,
    output logic [21:0] o_up,
    output logic [21:0] o_down,
    output logic [1:0]  o_found,
    output logic        o_valid,
    output logic        o_busy
);
    localparam int NUM_OBJ = 2;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t      state_q, state_d;
    logic        in_act;
    logic [1:0]  hit_d, hit_q;
    logic [10:0] x_q, y_q;
    logic        start_q, end_q;
    logic        acc_en, commit;
    logic        valid_q;

    logic [NUM_OBJ-1:0][10:0] left_w, right_w, up_w, down_w;
    logic [NUM_OBJ-1:0]       found_w;

    assign in_act   = i_valid && (i_x < 11'(H_ACTIVE)) && (i_y < 11'(V_ACTIVE));
    assign hit_d[0] = in_act && (i_r >= 8'(HI_TH)) && (i_g <= 8'(LO_TH)) && (i_b <= 8'(LO_TH));
    assign hit_d[1] = in_act && (i_b >= 8'(HI_TH)) && (i_r <= 8'(LO_TH)) && (i_g <= 8'(LO_TH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_q   <= 2'b00;
            x_q     <= 11'd0;
            y_q     <= 11'd0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            hit_q   <= hit_d;
            x_q     <= i_x;
            y_q     <= i_y;
            start_q <= i_frame_start;
            end_q   <= i_frame_end;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= commit;
        end
    end

    // Start+end together is a one-pixel frame: seed and commit in the same cycle.
    always_comb begin
        state_d = state_q;
        acc_en  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_q) begin
                    acc_en = 1'b1;
                    if (end_q) commit  = 1'b1;
                    else       state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_en = 1'b1;
                if (end_q) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    for (genvar k = 0; k < NUM_OBJ; k++) begin : g_obj
        color_bbox_obj #(.MIN_PIX(MIN_PIX)) u_obj (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .acc_en_i (acc_en),
            .seed_i   (start_q),
            .hit_i    (hit_q[k]),
            .commit_i (commit),
            .x_i      (x_q),
            .y_i      (y_q),
            .left_o   (left_w[k]),
            .right_o  (right_w[k]),
            .up_o     (up_w[k]),
            .down_o   (down_w[k]),
            .found_o  (found_w[k])
        );
    end

    assign o_left  = left_w;
    assign o_right = right_w;
    assign o_up    = up_w;
    assign o_down  = down_w;
    assign o_found = found_w;
    assign o_valid = valid_q;
    assign o_busy  = (state_q == ACCUM);
endmodule

// File: tb/tb_color_bbox_tracker.sv
// Randomised frame-level bench for color_bbox_tracker with a queue-based reference model.
module tb_color_bbox_tracker;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [10:0] i_x = '0, i_y = '0;
    logic [7:0]  i_r = '0, i_g = '0, i_b = '0;
    logic        i_frame_start = 1'b0, i_frame_end = 1'b0;
    logic [21:0] o_left, o_right, o_up, o_down;
    logic [1:0]  o_found;
    logic        o_valid, o_busy;

    color_bbox_tracker dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_x(i_x), .i_y(i_y),
        .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_frame_start(i_frame_start),
        .i_frame_end(i_frame_end), .o_left(o_left), .o_right(o_right), .o_up(o_up),
        .o_down(o_down), .o_found(o_found), .o_valid(o_valid), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int x; int y; int r; int g; int b; bit v; bit st; bit en;
    } pix_t;

    int   n_cmp = 0, n_mis = 0;
    int   vcount = 0;
    pix_t frame_q[$];
    pix_t cur_q[$];
    bit   m_active = 0;
    logic [10:0] e_l[2], e_r[2], e_u[2], e_d[2];
    logic [1:0]  e_found;

    always @(posedge i_clk) if (o_valid === 1'b1) vcount <= vcount + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int classify(pix_t p);
        if (!p.v || p.x >= 640 || p.y >= 480) return -1;
        if (p.r >= 160 && p.g <= 96 && p.b <= 96) return 0;
        if (p.b >= 160 && p.r <= 96 && p.g <= 96) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            e_l[k] = '0; e_r[k] = '0; e_u[k] = '0; e_d[k] = '0;
        end
        e_found = '0; m_active = 0; cur_q.delete();
    endtask

    task automatic model_commit();
        for (int k = 0; k < 2; k++) begin
            int cnt = 0, mnx = 2047, mxx = 0, mny = 2047, mxy = 0;
            foreach (cur_q[i]) if (classify(cur_q[i]) == k) begin
                cnt++;
                if (cur_q[i].x < mnx) mnx = cur_q[i].x;
                if (cur_q[i].x > mxx) mxx = cur_q[i].x;
                if (cur_q[i].y < mny) mny = cur_q[i].y;
                if (cur_q[i].y > mxy) mxy = cur_q[i].y;
            end
            e_found[k] = (cnt >= 64);
            if (cnt >= 64) begin
                e_l[k] = 11'(mnx); e_r[k] = 11'(mxx); e_u[k] = 11'(mny); e_d[k] = 11'(mxy);
            end
        end
    endtask

    // Frame semantics: a start opens a fresh pixel list, an end while open publishes it.
    task automatic model_frame(input int mid, output bit pulse, output bit mid_act);
        pulse = 0; mid_act = 0;
        foreach (frame_q[i]) begin
            if (frame_q[i].st) begin cur_q.delete(); m_active = 1; end
            if (m_active) cur_q.push_back(frame_q[i]);
            if (frame_q[i].en && m_active) begin model_commit(); m_active = 0; pulse = 1; end
            if (i == mid - 2) mid_act = m_active;
        end
    endtask

    task automatic clear_inputs();
        i_valid = 0; i_frame_start = 0; i_frame_end = 0;
        i_x = '0; i_y = '0; i_r = '0; i_g = '0; i_b = '0;
    endtask

    task automatic push(input int x, input int y, input int r, input int g, input int b, input bit v);
        pix_t p;
        p.x = x; p.y = y; p.r = r; p.g = g; p.b = b; p.v = v; p.st = 0; p.en = 0;
        frame_q.push_back(p);
    endtask

    task automatic run_frame(input string nm);
        bit exp_pulse, mid_act, v2;
        int v0, mid;
        mid = frame_q.size() / 2;
        model_frame(mid, exp_pulse, mid_act);
        v0 = vcount;
        v2 = 0;
        foreach (frame_q[i]) begin
            @(negedge i_clk);
            if (i == mid && frame_q.size() >= 8) begin
                n_cmp++;
                if (o_busy !== mid_act) begin
                    n_mis++; $display("FAIL %s busy_mid: got %b want %b", nm, o_busy, mid_act);
                end
            end
            i_valid = frame_q[i].v; i_x = 11'(frame_q[i].x); i_y = 11'(frame_q[i].y);
            i_r = 8'(frame_q[i].r); i_g = 8'(frame_q[i].g); i_b = 8'(frame_q[i].b);
            i_frame_start = frame_q[i].st; i_frame_end = frame_q[i].en;
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge i_clk);
            if (k == 1) clear_inputs();
            if (k == 2) v2 = o_valid;
        end
        n_cmp++;
        if (v2 !== exp_pulse) begin
            n_mis++; $display("FAIL %s valid_timing: got %b want %b", nm, v2, exp_pulse);
        end
        n_cmp++;
        if (vcount - v0 != int'(exp_pulse)) begin
            n_mis++; $display("FAIL %s pulse_count: got %0d want %0d", nm, vcount - v0, exp_pulse);
        end
        n_cmp++;
        if (o_found !== e_found) begin
            n_mis++; $display("FAIL %s found: got %b want %b", nm, o_found, e_found);
        end
        n_cmp++;
        if (o_left !== {e_l[1], e_l[0]} || o_right !== {e_r[1], e_r[0]}) begin
            n_mis++; $display("FAIL %s left_right: got %h/%h want %h/%h", nm, o_left, o_right,
                              {e_l[1], e_l[0]}, {e_r[1], e_r[0]});
        end
        n_cmp++;
        if (o_up !== {e_u[1], e_u[0]} || o_down !== {e_d[1], e_d[0]}) begin
            n_mis++; $display("FAIL %s up_down: got %h/%h want %h/%h", nm, o_up, o_down,
                              {e_u[1], e_u[0]}, {e_d[1], e_d[0]});
        end
        n_cmp++;
        if (o_busy !== m_active) begin
            n_mis++; $display("FAIL %s busy_end: got %b want %b", nm, o_busy, m_active);
        end
        frame_q.delete();
    endtask

    task automatic mark_frame();
        frame_q[0].st = 1;
        frame_q[frame_q.size()-1].en = 1;
    endtask

    task automatic check_idle_zero(input string nm);
        n_cmp++;
        if (o_left !== '0 || o_right !== '0 || o_up !== '0 || o_down !== '0) begin
            n_mis++; $display("FAIL %s boxes: got %h %h %h %h want 0", nm, o_left, o_right, o_up, o_down);
        end
        n_cmp++;
        if (o_found !== 2'b00 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_mis++; $display("FAIL %s flags: got found=%b valid=%b busy=%b want 0", nm, o_found, o_valid, o_busy);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst_n = 0;
        model_reset();
        repeat (3) @(negedge i_clk);
        check_idle_zero("reset_held");
        i_rst_n = 1;
        repeat (2) @(negedge i_clk);
        check_idle_zero("reset_released");
    endtask

    task automatic test_white();
        push(0, 0, 255, 255, 255, 1);
        for (int i = 0; i < 2000; i++)
            push($urandom_range(0, 639), $urandom_range(0, 479), 255, 255, 255, 1);
        push(639, 479, 255, 255, 255, 1);
        mark_frame();
        run_frame("white");
    endtask

    task automatic test_two_boxes();
        for (int y = 50; y <= 89; y++) for (int x = 100; x <= 149; x++) push(x, y, 200, 30, 30, 1);
        for (int y = 300; y <= 303; y++) for (int x = 400; x <= 419; x++) push(x, y, 20, 20, 220, 1);
        for (int i = 0; i < 300; i++)
            push($urandom_range(0, 639), $urandom_range(0, 479), 30, 200, 30, 1);
        frame_q.shuffle();
        mark_frame();
        run_frame("two_boxes");
        n_cmp++;
        if (o_left !== {11'd400, 11'd100} || o_right !== {11'd419, 11'd149} ||
            o_up !== {11'd300, 11'd50} || o_down !== {11'd303, 11'd89} || o_found !== 2'b11) begin
            n_mis++; $display("FAIL two_boxes_const: got %h %h %h %h %b want 400/100 419/149 300/50 303/89 11",
                              o_left, o_right, o_up, o_down, o_found);
        end
    endtask

    task automatic test_small_blue();
        for (int y = 10; y < 15; y++) for (int x = 20; x < 25; x++) push(x, y, 20, 20, 220, 1);
        mark_frame();
        run_frame("small_blue");
    endtask

    task automatic test_boundary();
        push(639, 479, 200, 30, 30, 1);
        for (int i = 0; i < 62; i++)
            push($urandom_range(1, 638), $urandom_range(1, 478), 200, 30, 30, 1);
        push(700, 10, 200, 30, 30, 1);
        push(10, 480, 200, 30, 30, 1);
        push(5, 5, 200, 30, 30, 0);
        push(0, 0, 200, 30, 30, 1);
        mark_frame();
        run_frame("boundary");
        n_cmp++;
        if (o_left[10:0] !== 11'd0 || o_right[10:0] !== 11'd639 || o_up[10:0] !== 11'd0 ||
            o_down[10:0] !== 11'd479 || o_found[0] !== 1'b1) begin
            n_mis++; $display("FAIL boundary_const: got %0d %0d %0d %0d %b want 0 639 0 479 1",
                              o_left[10:0], o_right[10:0], o_up[10:0], o_down[10:0], o_found[0]);
        end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 1000; i++)
            push($urandom_range(200, 600), $urandom_range(100, 400), 200, 30, 30, 1);
        frame_q[0].st = 1;
        push(10, 5, 200, 30, 30, 1);
        frame_q[frame_q.size()-1].st = 1;
        for (int x = 11; x <= 73; x++) push(x, 5, 200, 30, 30, 1);
        frame_q[frame_q.size()-1].en = 1;
        run_frame("restart");
        n_cmp++;
        if (o_left[10:0] !== 11'd10 || o_right[10:0] !== 11'd73 || o_up[10:0] !== 11'd5 ||
            o_down[10:0] !== 11'd5) begin
            n_mis++; $display("FAIL restart_const: got %0d %0d %0d %0d want 10 73 5 5",
                              o_left[10:0], o_right[10:0], o_up[10:0], o_down[10:0]);
        end
    endtask

    task automatic test_single_and_idle_end();
        push(300, 300, 200, 30, 30, 1);
        mark_frame();
        run_frame("single_pixel");
        push(40, 40, 20, 20, 220, 1);
        frame_q[0].en = 1;
        run_frame("idle_end");
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int n = $urandom_range(150, 600);
            for (int i = 0; i < n; i++) begin
                int sel = $urandom_range(0, 9);
                int r, g, b;
                if (sel < 4)      begin r = $urandom_range(150, 255); g = $urandom_range(0, 110); b = $urandom_range(0, 110); end
                else if (sel < 7) begin r = $urandom_range(0, 110); g = $urandom_range(0, 110); b = $urandom_range(150, 255); end
                else              begin r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255); end
                push($urandom_range(0, 720), $urandom_range(0, 520), r, g, b, $urandom_range(0, 9) != 0);
            end
            mark_frame();
            if ($urandom_range(0, 3) == 0) frame_q[n/3].st = 1;
            run_frame($sformatf("random%0d", f));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge i_clk);
        i_frame_start = 1; i_valid = 1; i_r = 200; i_g = 30; i_b = 30;
        for (int i = 0; i < 100; i++) begin
            i_x = 11'($urandom_range(0, 639)); i_y = 11'($urandom_range(0, 479));
            @(negedge i_clk);
            i_frame_start = 0;
        end
        n_cmp++;
        if (o_busy !== 1'b1) begin
            n_mis++; $display("FAIL reset_mid_busy: got %b want 1", o_busy);
        end
        #2 i_rst_n = 0;
        #1;
        check_idle_zero("reset_mid_async");
        clear_inputs();
        @(negedge i_clk);
        i_rst_n = 1;
        model_reset();
        push(50, 50, 200, 30, 30, 1);
        frame_q[0].en = 1;
        run_frame("reset_mid_end_only");
        check_idle_zero("reset_mid_final");
    endtask

    initial begin
        test_reset();
        test_white();
        test_two_boxes();
        test_small_blue();
        test_boundary();
        test_restart();
        test_single_and_idle_end();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
